// File: rtl/int_frac_to_bf16.sv
// int_frac_to_bf16
//
// Rebuilds one bf16 value from a 32-bit unsigned integer part, an fp16
// fractional part in [0,1) and a sign bit. The split exp/softmax results
// are recombined here before write-back.
//
// The two parts are loaded into a 56-bit fixed-point accumulator
// {int[31:0], frac[23:0]}. The accumulator is then normalised one step per
// cycle: a coarse shift of COARSE_STEP bits, or a single-bit shift. Doing
// it one step per cycle avoids a full leading-zero counter and barrel
// shifter.
//
// Build option:
//   INT_FRAC_TO_BF16_RNE_EN - when defined, the mantissa is rounded to
//                             nearest-even. When undefined, it is
//                             truncated. Latency is the same in both builds.
//
// Parameters:
//   COARSE_STEP   - coarse left-shift step used during normalisation (4 or 8)
//
// Ports:
//   clk           - clock; all state changes on the rising edge
//   rst           - synchronous active-high reset
//   in_valid      - request valid
//   in_ready      - block can accept a request (high only in IDLE, low in reset)
//   in_sign       - sign bit, copied to the result
//   in_int_u32    - integer part, unsigned
//   in_frac_fp16  - fractional part as fp16; its sign bit is ignored
//   out_valid     - result valid; held until accepted
//   out_ready     - consumer accepts the result
//   out_bf16      - assembled bf16 value
//   out_err       - fraction was illegal (stored exp >= 15) and was treated as 0

module int_frac_to_bf16 #(
  parameter int unsigned COARSE_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [31:0] in_int_u32,
  input  logic [15:0] in_frac_fp16,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_bf16,
  output logic        out_err
);

  // Exponent of bit 55 of the accumulator: 2^31 has biased exponent 127+31.
  localparam logic [8:0] ExpLoad   = 9'd158;
  localparam logic [8:0] CoarseExp = 9'(COARSE_STEP);

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [55:0] acc_q, acc_d;
  logic [8:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic [15:0] out_bf16_q, out_bf16_d;
  logic        out_err_q, out_err_d;

  // ---------------------------------------------------------------------------
  // fp16 fraction to 24-bit fixed point (value * 2^24), exact for e in 1..14
  // ---------------------------------------------------------------------------
  logic [4:0]  frac_e;
  logic [9:0]  frac_m;
  logic [23:0] frac_fx;
  logic        frac_illegal;

  assign frac_e = in_frac_fp16[14:10];
  assign frac_m = in_frac_fp16[9:0];

  always_comb begin
    frac_fx      = '0;
    frac_illegal = 1'b0;
    if (frac_e == 5'd0) begin
      // Subnormal fractions are below 2^-14; they are dropped.
      frac_fx = '0;
    end else if (frac_e >= 5'd15) begin
      // The value is >= 1.0, or it is inf/NaN. Such a fraction is not legal.
      frac_illegal = 1'b1;
    end else begin
      // The value is 1.m * 2^(e-15). Scaled by 2^24, this is {1,m} << (e-1).
      frac_fx = {13'd0, 1'b1, frac_m} << (frac_e - 5'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Normalisation decisions and result packing
  // ---------------------------------------------------------------------------
  logic        acc_zero;
  logic        coarse_zero;
  logic [14:0] trunc_mag;
  logic [14:0] result_mag;

  assign acc_zero    = (acc_q == '0);
  assign coarse_zero = (acc_q[55 -: COARSE_STEP] == '0);

  // The leading one at acc[55] is implicit. The next 7 bits form the mantissa.
  assign trunc_mag = {exp_q[7:0], acc_q[54:48]};

`ifdef INT_FRAC_TO_BF16_RNE_EN
  logic round_up;

  // Round to nearest, ties to even. A mantissa carry-out rolls into the
  // exponent. The exponent is at most 158, so the rounded value stays finite.
  assign round_up   = acc_q[47] & ((|acc_q[46:0]) | acc_q[48]);
  assign result_mag = trunc_mag + {14'd0, round_up};
`else
  assign result_mag = trunc_mag;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      out_bf16_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      err_q      <= err_d;
      out_bf16_q <= out_bf16_d;
      out_err_q  <= out_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    err_d      = err_q;
    out_bf16_d = out_bf16_q;
    out_err_d  = out_err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StNorm;
          acc_d   = {in_int_u32, frac_fx};
          exp_d   = ExpLoad;
          sign_d  = in_sign;
          err_d   = frac_illegal;
        end
      end

      StNorm: begin
        if (acc_zero) begin
          state_d    = StDone;
          out_bf16_d = {sign_q, 15'h0000};
          out_err_d  = err_q;
        end else if (coarse_zero) begin
          acc_d = acc_q << COARSE_STEP;
          exp_d = exp_q - CoarseExp;
        end else if (!acc_q[55]) begin
          acc_d = acc_q << 1;
          exp_d = exp_q - 9'd1;
        end else begin
          state_d    = StDone;
          out_bf16_d = {sign_q, result_mag};
          out_err_d  = err_q;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StDone);
    out_bf16  = out_bf16_q;
    out_err   = out_err_q;
  end

endmodule

// File: tb/tb_int_frac_to_bf16.sv
// Testbench for int_frac_to_bf16 with the default COARSE_STEP of 8.
// It applies directed vectors from a table, then randomised requests that are
// compared against an arithmetic reference model. It also runs hand-written
// sequences for output back-pressure and for a reset in the middle of a
// transaction.

module tb_int_frac_to_bf16;

  localparam int unsigned Step = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [31:0] in_int_u32;
  logic [15:0] in_frac_fp16;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bf16;
  logic        out_err;

  int checks;
  int errors;

  int_frac_to_bf16 #(
    .COARSE_STEP(Step)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_int_u32   (in_int_u32),
    .in_frac_fp16 (in_frac_fp16),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bf16     (out_bf16),
    .out_err      (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model. It treats the value as an integer scaled by 2^24. The
  // leading one is found by search. The bf16 fields are then derived with
  // plain arithmetic.
  function automatic void model(input logic s, input logic [31:0] iv, input logic [15:0] f,
                                output logic [15:0] bf, output logic err, output int cyc);
    longint unsigned v, fx, sh, rem, half;
    int e, p, lz, ex;
    logic up;
    e   = int'(f[14:10]);
    err = 1'b0;
    fx  = 0;
    if (e >= 15) err = 1'b1;
    else if (e >= 1) fx = (longint'(1024) + longint'(f[9:0])) * (longint'(1) << (e - 1));
    v = (longint'(iv) << 24) + fx;
    p = -1;
    for (int i = 55; i >= 0; i--) begin
      if (p < 0 && ((v >> i) & 1) == 1) p = i;
    end
    if (p < 0) begin
      bf  = {s, 15'h0000};
      cyc = 1;
    end else begin
      lz  = 55 - p;
      cyc = lz / Step + lz % Step + 1;
      ex  = 127 + (p - 24);
      if (p >= 7) sh = v >> (p - 7);
      else sh = v << (7 - p);
      up = 1'b0;
`ifdef INT_FRAC_TO_BF16_RNE_EN
      if (p >= 8) begin
        rem  = v & ((longint'(1) << (p - 7)) - 1);
        half = longint'(1) << (p - 8);
        up   = (rem > half) || (rem == half && (sh & 1) == 1);
      end
`else
      rem  = 0;
      half = 0;
`endif
      bf = {s, 15'((longint'(ex) << 7) + (sh & 127) + longint'(up))};
    end
  endfunction

  // Runs one full transaction. The cycle count is the number of rising edges
  // after the accept edge until out_valid is seen.
  task automatic run_txn(input logic s, input logic [31:0] iv, input logic [15:0] f,
                         input int hold, output logic [15:0] bf, output logic err,
                         output int cyc);
    logic [15:0] first_bf;
    bf  = '0;
    err = 1'b0;
    cyc = 0;
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid     = 1'b1;
    in_sign      = s;
    in_int_u32   = iv;
    in_frac_fp16 = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid still 0 after %0d cycles, expected 1", cyc);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end else begin
      bf       = out_bf16;
      err      = out_err;
      first_bf = out_bf16;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_bf16", {16'd0, out_bf16}, {16'd0, first_bf});
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("valid_drop", {31'd0, out_valid}, 32'd0);
    end
  endtask

  typedef struct {
    logic        sign;
    logic [31:0] ival;
    logic [15:0] frac;
    logic [15:0] bf;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  logic [15:0] got_bf, exp_bf;
  logic        got_err, exp_err;
  int          got_cyc, exp_cyc;
  logic [31:0] r_int;
  logic [15:0] r_frac;
  logic        r_sign;

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_sign      = 1'b0;
    in_int_u32   = '0;
    in_frac_fp16 = '0;
    out_ready    = 1'b0;

    vecs[0] = '{1'b0, 32'h1,        16'h0000, 16'h3F80, 1'b0, 11};
    vecs[1] = '{1'b0, 32'h3,        16'h3800, 16'h4060, 1'b0, 10};
    vecs[2] = '{1'b1, 32'h0,        16'h3C00, 16'h8000, 1'b1, 1};
    vecs[3] = '{1'b0, 32'h0,        16'h0200, 16'h0000, 1'b0, 1};
    vecs[4] = '{1'b0, 32'h101,      16'h0000, 16'h4380, 1'b0, 10};
    vecs[5] = '{1'b0, 32'h0,        16'h3400, 16'h3E80, 1'b0, 6};
    vecs[6] = '{1'b1, 32'h3,        16'h3800, 16'hC060, 1'b0, 10};
`ifdef INT_FRAC_TO_BF16_RNE_EN
    vecs[7] = '{1'b0, 32'h1FF,      16'h3800, 16'h4400, 1'b0, 10};
    vecs[8] = '{1'b0, 32'h103,      16'h0000, 16'h4382, 1'b0, 10};
    vecs[9] = '{1'b0, 32'hFFFFFFFF, 16'h0000, 16'h4F80, 1'b0, 1};
`else
    vecs[7] = '{1'b0, 32'h1FF,      16'h3800, 16'h43FF, 1'b0, 10};
    vecs[8] = '{1'b0, 32'h103,      16'h0000, 16'h4381, 1'b0, 10};
    vecs[9] = '{1'b0, 32'hFFFFFFFF, 16'h0000, 16'h4F7F, 1'b0, 1};
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bf16", {16'd0, out_bf16}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      run_txn(vecs[i].sign, vecs[i].ival, vecs[i].frac, 0, got_bf, got_err, got_cyc);
      check($sformatf("vec%0d_bf16", i), {16'd0, got_bf}, {16'd0, vecs[i].bf});
      check($sformatf("vec%0d_err", i), {31'd0, got_err}, {31'd0, vecs[i].err});
      check($sformatf("vec%0d_cycles", i), got_cyc, vecs[i].cyc);
    end

    // Output back-pressure: the result must hold while out_ready is low.
    run_txn(1'b0, 32'hFFFFFFFF, 16'h0000, 5, got_bf, got_err, got_cyc);
    model(1'b0, 32'hFFFFFFFF, 16'h0000, exp_bf, exp_err, exp_cyc);
    check("hold_result", {16'd0, got_bf}, {16'd0, exp_bf});

    // Reset in the middle of normalisation. The transaction is abandoned.
    @(negedge clk);
    in_valid   = 1'b1;
    in_sign    = 1'b0;
    in_int_u32 = 32'h1;
    in_frac_fp16 = 16'h0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_bf16", {16'd0, out_bf16}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_idle", {31'd0, in_ready}, 32'd1);
    repeat (12) begin
      @(posedge clk);
      #1;
      check("midrst_no_out", {31'd0, out_valid}, 32'd0);
    end
    run_txn(1'b0, 32'h1, 16'h0000, 0, got_bf, got_err, got_cyc);
    check("postrst_bf16", {16'd0, got_bf}, 32'h3F80);
    check("postrst_cycles", got_cyc, 11);

    // Randomised requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      r_int  = $urandom >> $urandom_range(0, 32);
      r_frac = 16'($urandom_range(0, 65535));
      r_sign = 1'($urandom_range(0, 1));
      if (n % 7 == 0) r_int = '0;
      model(r_sign, r_int, r_frac, exp_bf, exp_err, exp_cyc);
      run_txn(r_sign, r_int, r_frac, 0, got_bf, got_err, got_cyc);
      check($sformatf("rnd%0d_bf16 int=%0h frac=%0h", n, r_int, r_frac),
            {16'd0, got_bf}, {16'd0, exp_bf});
      check($sformatf("rnd%0d_err", n), {31'd0, got_err}, {31'd0, exp_err});
      check($sformatf("rnd%0d_cycles", n), got_cyc, exp_cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_frac_to_bf16.md
Name: int_frac_to_bf16

Overview:
- Sequential inverse of the bf16 integer/fraction splitter.
- Takes a 32-bit unsigned integer part, an fp16 fractional part in [0,1) and a sign bit, and reassembles a single bf16 value.
- Uses a 56-bit fixed-point accumulator, normalised iteratively to save area.
- Sits on the datapath where split exp/softmax results are recombined before write-back; valid/ready on both sides.

Parameters:
COARSE_STEP, 8, coarse left-shift step in NORM; legal values 4 or 8.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept; high only in IDLE
in_sign  input  1  sign copied to the result
in_int_u32  input  32  integer part, unsigned
in_frac_fp16  input  16  fractional part, fp16; sign bit ignored
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts result
out_bf16  output  16  assembled bf16
out_err  output  1  fraction was illegal (stored exp >= 15) and was treated as 0

Behaviour:
- Reset:
  - state=IDLE; out_valid=0, out_bf16=16'h0000, out_err=0; acc and exp cleared.
  - in_ready=0 while rst is high.
  - Reset mid-operation abandons the transaction; no output is produced for it.
- States: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register the inputs and go to NORM.
  - Accumulator load: acc[55:0] = {in_int_u32, frac_fx[23:0]}; exp register = 158; sign captured.
- frac_fx (e = frac[14:10]):
  - e==0: frac_fx = 0 (subnormal dropped).
  - 1<=e<=14: frac_fx = {1, frac[9:0]} << (e-1), i.e. 24 fractional bits, exact.
  - e>=15: frac_fx = 0; captured err=1.
- NORM, one decision per cycle, in priority order:
  - acc==0 -> DONE.
  - acc[55:56-COARSE_STEP]==0 -> acc <<= COARSE_STEP, exp -= COARSE_STEP.
  - acc[55]==0 -> acc <<= 1, exp -= 1.
  - else -> DONE.
- Cycle count: with lz = leading zeros of the nonzero acc, NORM occupies floor(lz/COARSE_STEP) + (lz mod COARSE_STEP) + 1 cycles. Zero acc: 1 cycle.
- Latency: accept at edge T; out_valid is high from cycle T+1+k, where k = NORM cycles.
- Result, registered on the NORM->DONE transition:
  - Zero acc: out_bf16 = {sign, 15'h0}.
  - Otherwise: out_bf16 = {sign, exp[7:0], acc[54:48]}, truncated.
  - exp range 113..158, so the result never overflows or goes subnormal.
  - out_err = captured err.
- DONE:
  - out_valid=1; out_bf16 and out_err are stable.
  - On out_ready -> IDLE and out_valid=0 next cycle.
  - No new input is accepted in DONE; no back-to-back overlap.
- Width rules: exp is 9-bit internally and never negative; acc shifts fill zeros from the LSB.

Optional Feature:
INT_FRAC_TO_BF16_RNE_EN
- Defined: round-to-nearest-even at the DONE transition.
  - lsb=acc[48], r=acc[47], s=|acc[46:0].
  - Increment {exp, mant} when r&&(s||lsb).
  - Mantissa carry-out increments exp (max 159, safe).
- Undefined: truncation as above.
- Latency is identical in both builds.

Test Plan:
- int=1, frac=0x0000, sign=0 -> out_bf16=0x3F80, out_err=0; out_valid 11 cycles after accept (COARSE_STEP=8).
- int=3, frac=0x3800 (0.5) -> 0x4060, out_valid 10 cycles after accept.
- int=0, frac=0x3C00 (illegal 1.0), sign=1 -> out_bf16=0x8000, out_err=1, NORM 1 cycle; int=0, frac=0x0200 (subnormal) -> 0x0000, out_err=0.
- int=0x1FF, frac=0x3800 -> 0x43FF without RNE_EN, 0x4400 with it. int=0x101 -> 0x4380 in both builds (tie to even). int=0x103 -> 0x4381 without, 0x4382 with.
- int=0xFFFFFFFF, frac=0 -> 0x4F7F (truncation, NORM 1 cycle), 0x4F80 with RNE_EN. Hold out_ready=0 for 5 cycles -> out_valid and out_bf16 stable, in_ready=0.
- Assert rst for 1 cycle mid-NORM -> next cycle state IDLE, out_valid=0, out_bf16=0; a following request int=1 completes normally with 0x3F80.
